el2_lsu_dccm_arb: RTL and testbench

Arbitrates the single-ported DCCM between three requesters: the LSU load pipe (read), the store-buffer drain (write) and the DMA slave port (read or write). It drives exactly one DCCM access per cycle to the DCCM memory and steers the one-cycle-latency read data back to its owner. A starvation counter guarantees DMA forward progress by stalling the LSU pipe for one grant.

---
 rtl/el2_lsu_dccm_arb.sv | 117 +++++++++++
 tb/tb_el2_lsu_dccm_arb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/el2_lsu_dccm_arb.sv
`default_nettype none
// el2_lsu_dccm_arb: arbitrates the single-ported DCCM between LSU loads, store-buffer drain and DMA.
// Rev 1.0
module el2_lsu_dccm_arb #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39,
  parameter int DMA_STALL_MAX    = 4
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic                        lsu_rd_req,
  input  logic [DCCM_BITS-1:0]        lsu_rd_addr_lo,
  input  logic [DCCM_BITS-1:0]        lsu_rd_addr_hi,
  output logic                        lsu_rd_gnt,
  output logic                        lsu_dccm_stall,
  output logic                        lsu_rd_valid,
  input  logic                        stbuf_req,
  input  logic                        stbuf_full,
  input  logic [DCCM_BITS-1:0]        stbuf_addr_lo,
  input  logic [DCCM_BITS-1:0]        stbuf_addr_hi,
  input  logic [DCCM_FDATA_WIDTH-1:0] stbuf_data_lo,
  input  logic [DCCM_FDATA_WIDTH-1:0] stbuf_data_hi,
  output logic                        stbuf_gnt,
  input  logic                        dma_req,
  input  logic                        dma_write,
  input  logic [DCCM_BITS-1:0]        dma_addr,
  input  logic [DCCM_FDATA_WIDTH-1:0] dma_wdata,
  output logic                        dma_gnt,
  output logic                        dma_rd_valid,
  output logic                        dccm_wren,
  output logic                        dccm_rden,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi
);

  typedef enum logic [0:0] {
    NORMAL    = 1'b0,
    FORCE_DMA = 1'b1
  } state_t;

  localparam logic [3:0] STALL_MAX  = 4'(DMA_STALL_MAX);
  localparam logic [3:0] STALL_LAST = 4'(DMA_STALL_MAX - 1);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_cnt_nxt;
  logic       rd_own_lsu, rd_own_dma;
  logic       dma_rd_sel, dma_wr_sel, dma_blocked;

  always_comb begin
    lsu_rd_gnt = 1'b0;
    stbuf_gnt  = 1'b0;
    dma_gnt    = 1'b0;
    if (rst_l) begin
      if (state == FORCE_DMA) begin
        // LSU is held off entirely; it sees lsu_dccm_stall and keeps its request.
        if (dma_req)        dma_gnt   = 1'b1;
        else if (stbuf_req) stbuf_gnt = 1'b1;
      end else begin
        if (lsu_rd_req)                   lsu_rd_gnt = 1'b1;
        else if (stbuf_req && stbuf_full) stbuf_gnt  = 1'b1;
        else if (dma_req)                 dma_gnt    = 1'b1;
        else if (stbuf_req)               stbuf_gnt  = 1'b1;
      end
    end
  end

  assign dma_rd_sel = dma_gnt & ~dma_write;
  assign dma_wr_sel = dma_gnt & dma_write;

  assign dccm_rden = lsu_rd_gnt | dma_rd_sel;
  assign dccm_wren = stbuf_gnt | dma_wr_sel;

  assign dccm_rd_addr_lo = lsu_rd_gnt ? lsu_rd_addr_lo : (dma_rd_sel ? dma_addr : '0);
  assign dccm_rd_addr_hi = lsu_rd_gnt ? lsu_rd_addr_hi : (dma_rd_sel ? dma_addr : '0);
  assign dccm_wr_addr_lo = stbuf_gnt  ? stbuf_addr_lo  : (dma_wr_sel ? dma_addr : '0);
  assign dccm_wr_addr_hi = stbuf_gnt  ? stbuf_addr_hi  : (dma_wr_sel ? dma_addr : '0);
  assign dccm_wr_data_lo = stbuf_gnt  ? stbuf_data_lo  : (dma_wr_sel ? dma_wdata : '0);
  assign dccm_wr_data_hi = stbuf_gnt  ? stbuf_data_hi  : (dma_wr_sel ? dma_wdata : '0);

  assign dma_blocked = dma_req & ~dma_gnt;

  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    if (!dma_blocked)               starve_cnt_nxt = 4'd0;
    else if (starve_cnt < STALL_MAX) starve_cnt_nxt = starve_cnt + 4'd1;
    case (state)
      NORMAL:    if (dma_blocked && (starve_cnt == STALL_LAST)) state_nxt = FORCE_DMA;
      FORCE_DMA: if (dma_gnt || !dma_req)                       state_nxt = NORMAL;
      default:   state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state      <= NORMAL;
      starve_cnt <= 4'd0;
      rd_own_lsu <= 1'b0;
      rd_own_dma <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      rd_own_lsu <= lsu_rd_gnt;
      rd_own_dma <= dma_rd_sel;
    end
  end

  assign lsu_dccm_stall = (state == FORCE_DMA);
  assign lsu_rd_valid   = rd_own_lsu;
  assign dma_rd_valid   = rd_own_dma;

endmodule
`default_nettype wire

// File: tb/tb_el2_lsu_dccm_arb.sv
`default_nettype none
// tb_el2_lsu_dccm_arb: directed stimulus with a queue-based scoreboard for the DCCM arbiter.
// Rev 1.0
module tb_el2_lsu_dccm_arb;

  logic        clk, rst_l;
  logic        lsu_rd_req, lsu_rd_gnt, lsu_dccm_stall, lsu_rd_valid;
  logic [15:0] lsu_rd_addr_lo, lsu_rd_addr_hi;
  logic        stbuf_req, stbuf_full, stbuf_gnt;
  logic [15:0] stbuf_addr_lo, stbuf_addr_hi;
  logic [38:0] stbuf_data_lo, stbuf_data_hi;
  logic        dma_req, dma_write, dma_gnt, dma_rd_valid;
  logic [15:0] dma_addr;
  logic [38:0] dma_wdata;
  logic        dccm_wren, dccm_rden;
  logic [15:0] dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_rd_addr_lo, dccm_rd_addr_hi;
  logic [38:0] dccm_wr_data_lo, dccm_wr_data_hi;

  el2_lsu_dccm_arb #(.DCCM_BITS(16), .DCCM_FDATA_WIDTH(39), .DMA_STALL_MAX(4)) dut (
    .clk(clk), .rst_l(rst_l),
    .lsu_rd_req(lsu_rd_req), .lsu_rd_addr_lo(lsu_rd_addr_lo), .lsu_rd_addr_hi(lsu_rd_addr_hi),
    .lsu_rd_gnt(lsu_rd_gnt), .lsu_dccm_stall(lsu_dccm_stall), .lsu_rd_valid(lsu_rd_valid),
    .stbuf_req(stbuf_req), .stbuf_full(stbuf_full),
    .stbuf_addr_lo(stbuf_addr_lo), .stbuf_addr_hi(stbuf_addr_hi),
    .stbuf_data_lo(stbuf_data_lo), .stbuf_data_hi(stbuf_data_hi), .stbuf_gnt(stbuf_gnt),
    .dma_req(dma_req), .dma_write(dma_write), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rd_valid(dma_rd_valid),
    .dccm_wren(dccm_wren), .dccm_rden(dccm_rden),
    .dccm_wr_addr_lo(dccm_wr_addr_lo), .dccm_wr_addr_hi(dccm_wr_addr_hi),
    .dccm_rd_addr_lo(dccm_rd_addr_lo), .dccm_rd_addr_hi(dccm_rd_addr_hi),
    .dccm_wr_data_lo(dccm_wr_data_lo), .dccm_wr_data_hi(dccm_wr_data_hi)
  );

  typedef struct packed {
    logic [2:0]  gnt;   // {lsu, stbuf, dma}
    logic        wren;
    logic        rden;
    logic        stall;
    logic [15:0] wal, wah, ral, rah;
    logic [38:0] wdl, wdh;
  } gexp_t;
  typedef struct { int cyc; gexp_t v; } grec_t;
  typedef struct { int cyc; logic [1:0] v; } rrec_t;  // {lsu_rd_valid, dma_rd_valid}

  grec_t gq[$];
  rrec_t rq[$];
  int    cyc = 0;
  int    compared = 0;
  int    mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop an expectation whenever the DUT shows a grant/enable or a read-valid pulse.
  gexp_t act;
  grec_t ge;
  rrec_t re;
  always @(negedge clk) begin
    act = {lsu_rd_gnt, stbuf_gnt, dma_gnt, dccm_wren, dccm_rden, lsu_dccm_stall,
           dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_rd_addr_lo, dccm_rd_addr_hi,
           dccm_wr_data_lo, dccm_wr_data_hi};
    if (lsu_rd_gnt || stbuf_gnt || dma_gnt || dccm_wren || dccm_rden) begin
      compared++;
      if (gq.size() == 0) begin
        mismatched++;
        $display("FAIL gnt_unexpected cyc=%0d got=%h required=none", cyc, act);
      end else begin
        ge = gq.pop_front();
        if (ge.cyc != cyc || act !== ge.v) begin
          mismatched++;
          $display("FAIL gnt cyc=%0d got=%h required=%h at cyc %0d", cyc, act, ge.v, ge.cyc);
        end
      end
    end
    if (lsu_rd_valid || dma_rd_valid) begin
      compared++;
      if (rq.size() == 0) begin
        mismatched++;
        $display("FAIL rd_valid_unexpected cyc=%0d got=%b%b required=none", cyc, lsu_rd_valid, dma_rd_valid);
      end else begin
        re = rq.pop_front();
        if (re.cyc != cyc || {lsu_rd_valid, dma_rd_valid} !== re.v) begin
          mismatched++;
          $display("FAIL rd_valid cyc=%0d got=%b%b required=%b at cyc %0d",
                   cyc, lsu_rd_valid, dma_rd_valid, re.v, re.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_g(input logic [2:0] g, input logic wr, input logic rd, input logic st,
                       input logic [15:0] wal, input logic [15:0] wah,
                       input logic [15:0] ral, input logic [15:0] rah,
                       input logic [38:0] wdl, input logic [38:0] wdh);
    grec_t r;
    r.cyc = cyc;
    r.v   = {g, wr, rd, st, wal, wah, ral, rah, wdl, wdh};
    gq.push_back(r);
  endtask

  task automatic exp_rd(input logic [1:0] v);
    rrec_t r;
    r.cyc = cyc + 1;
    r.v   = v;
    rq.push_back(r);
  endtask

  task automatic exp_lsu(input logic [15:0] lo, input logic [15:0] hi, input logic st, input logic data_back);
    exp_g(3'b100, 1'b0, 1'b1, st, 16'h0, 16'h0, lo, hi, 39'h0, 39'h0);
    if (data_back) exp_rd(2'b10);
  endtask

  task automatic exp_stb(input logic [15:0] alo, input logic [15:0] ahi,
                         input logic [38:0] dlo, input logic [38:0] dhi, input logic st);
    exp_g(3'b010, 1'b1, 1'b0, st, alo, ahi, 16'h0, 16'h0, dlo, dhi);
  endtask

  task automatic exp_dma_rd(input logic [15:0] a, input logic st);
    exp_g(3'b001, 1'b0, 1'b1, st, 16'h0, 16'h0, a, a, 39'h0, 39'h0);
    exp_rd(2'b01);
  endtask

  task automatic exp_dma_wr(input logic [15:0] a, input logic [38:0] d, input logic st);
    exp_g(3'b001, 1'b1, 1'b0, st, a, a, 16'h0, 16'h0, d, d);
  endtask

  initial begin
    // Reset held with every requester asking: nothing may be granted.
    rst_l = 1'b0;
    lsu_rd_req = 1'b1; lsu_rd_addr_lo = 16'h0010; lsu_rd_addr_hi = 16'h0014;
    stbuf_req = 1'b1; stbuf_full = 1'b1;
    stbuf_addr_lo = 16'h0000; stbuf_addr_hi = 16'h0000;
    stbuf_data_lo = 39'h0; stbuf_data_hi = 39'h0;
    dma_req = 1'b1; dma_write = 1'b0; dma_addr = 16'h0000; dma_wdata = 39'h0;
    repeat (3) tick();

    rst_l = 1'b1;
    exp_lsu(16'h0010, 16'h0014, 1'b0, 1'b1);
    tick();
    lsu_rd_req = 1'b0; stbuf_req = 1'b0; stbuf_full = 1'b0; dma_req = 1'b0;
    tick();

    // Read steering: LSU read then DMA read on consecutive cycles.
    lsu_rd_req = 1'b1; lsu_rd_addr_lo = 16'h0100; lsu_rd_addr_hi = 16'h0100;
    exp_lsu(16'h0100, 16'h0100, 1'b0, 1'b1);
    tick();
    lsu_rd_req = 1'b0; dma_req = 1'b1; dma_write = 1'b0; dma_addr = 16'h0200;
    exp_dma_rd(16'h0200, 1'b0);
    tick();
    dma_req = 1'b0;
    repeat (2) tick();

    // Starvation: continuous LSU traffic, DMA write forced through on the fifth cycle.
    lsu_rd_req = 1'b1; lsu_rd_addr_lo = 16'h0040; lsu_rd_addr_hi = 16'h0044;
    dma_req = 1'b1; dma_write = 1'b1; dma_addr = 16'h0300; dma_wdata = 39'h5A_1234_5678;
    for (int i = 0; i < 4; i++) begin exp_lsu(16'h0040, 16'h0044, 1'b0, 1'b1); tick(); end
    exp_dma_wr(16'h0300, 39'h5A_1234_5678, 1'b1);
    tick();
    // A fresh DMA read must again wait a full four cycles (counter restarted at 0).
    dma_write = 1'b0; dma_addr = 16'h0304;
    for (int i = 0; i < 4; i++) begin exp_lsu(16'h0040, 16'h0044, 1'b0, 1'b1); tick(); end
    exp_dma_rd(16'h0304, 1'b1);
    tick();
    dma_req = 1'b0;
    exp_lsu(16'h0040, 16'h0044, 1'b0, 1'b1);
    tick();
    lsu_rd_req = 1'b0;
    tick();

    // Full store buffer outranks DMA.
    stbuf_req = 1'b1; stbuf_full = 1'b1;
    stbuf_addr_lo = 16'h0080; stbuf_addr_hi = 16'h0080;
    stbuf_data_lo = 39'h11_1111_1111; stbuf_data_hi = 39'h22_2222_2222;
    dma_req = 1'b1; dma_write = 1'b0; dma_addr = 16'h0400;
    exp_stb(16'h0080, 16'h0080, 39'h11_1111_1111, 39'h22_2222_2222, 1'b0);
    tick();
    stbuf_req = 1'b0; stbuf_full = 1'b0;
    exp_dma_rd(16'h0400, 1'b0);
    tick();
    dma_req = 1'b0;
    tick();

    // Non-full store buffer yields to DMA; then a misaligned store drains.
    stbuf_req = 1'b1; stbuf_full = 1'b0;
    stbuf_addr_lo = 16'h0FFC; stbuf_addr_hi = 16'h1000;
    stbuf_data_lo = 39'h7F_0000_0001; stbuf_data_hi = 39'h00_ABCD_EF01;
    dma_req = 1'b1; dma_write = 1'b1; dma_addr = 16'h0500; dma_wdata = 39'h03_0000_00FF;
    exp_dma_wr(16'h0500, 39'h03_0000_00FF, 1'b0);
    tick();
    dma_req = 1'b0;
    exp_stb(16'h0FFC, 16'h1000, 39'h7F_0000_0001, 39'h00_ABCD_EF01, 1'b0);
    tick();
    stbuf_req = 1'b0;
    tick();

    // Forced DMA beats a full store buffer; the store follows next cycle.
    lsu_rd_req = 1'b1; dma_req = 1'b1; dma_write = 1'b0; dma_addr = 16'h0600;
    for (int i = 0; i < 4; i++) begin exp_lsu(16'h0040, 16'h0044, 1'b0, 1'b1); tick(); end
    stbuf_req = 1'b1; stbuf_full = 1'b1;
    stbuf_addr_lo = 16'h0090; stbuf_addr_hi = 16'h0094;
    stbuf_data_lo = 39'h33_0000_0003; stbuf_data_hi = 39'h44_0000_0004;
    exp_dma_rd(16'h0600, 1'b1);
    tick();
    lsu_rd_req = 1'b0; dma_req = 1'b0;
    exp_stb(16'h0090, 16'h0094, 39'h33_0000_0003, 39'h44_0000_0004, 1'b0);
    tick();
    stbuf_req = 1'b0; stbuf_full = 1'b0;
    tick();

    // Reset lands right after an LSU read grant: its data-valid must be dropped.
    lsu_rd_req = 1'b1; lsu_rd_addr_lo = 16'h0700; lsu_rd_addr_hi = 16'h0704;
    exp_lsu(16'h0700, 16'h0704, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst_l = 1'b0;
    tick();
    lsu_rd_req = 1'b0;
    tick();
    rst_l = 1'b1;
    repeat (3) tick();

    compared++;
    if (gq.size() != 0) begin
      mismatched++;
      $display("FAIL gnt_pending got=%0d outstanding required=0", gq.size());
    end
    compared++;
    if (rq.size() != 0) begin
      mismatched++;
      $display("FAIL rd_valid_pending got=%0d outstanding required=0", rq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
